// File: rtl/memwb_stage.sv
// memwb_stage: parametrised MEM/WB pipeline stage with a 2-entry elastic buffer.
//
// The stage has a main register (M) and a skid register (S). M always drives the
// out_* ports. S takes one extra entry when writeback stalls. Because of S,
// in_ready can come straight from a flop and does not depend on out_ready.
//
// Ports:
//   clk, reset           rising-edge clock; synchronous active-high reset
//   flush                drops every held entry and any input offered in the same cycle
//   in_valid / in_ready  upstream handshake
//   in_*                 entry fields: mem_to_reg, reg_write, alu_out, mem_data, rd, opcode
//   out_valid / out_ready  downstream (writeback) handshake
//   out_*                head-entry fields; out_reg_write is forced low while out_valid=0
//
// Optional feature, enabled by defining MEMWB_WBMUX_EN:
//   fwd_rs      (in)   source register of the consumer, used by the hazard unit
//   wb_data     (out)  out_mem_to_reg ? out_mem_data : out_alu_out, or 0 when out_valid=0
//   wb_fwd_hit  (out)  out_valid & out_reg_write & (out_rd == fwd_rs)
module memwb_stage #(
    parameter int DATA_W        = 16,
    parameter int RD_W          = 4,
    parameter int OP_W          = 4,
    parameter int ZERO_REG_NOWR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [OP_W-1:0]   in_opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mem_to_reg,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [OP_W-1:0]   out_opcode
`ifdef MEMWB_WBMUX_EN
    ,
    input  logic [RD_W-1:0]   fwd_rs,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_fwd_hit
`endif
);

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_write;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] mem_data;
        logic [RD_W-1:0]   rd;
        logic [OP_W-1:0]   opcode;
    } entry_t;

    // Occupancy: EMPTY (mv=0), ONE (mv=1, sv=0), FULL (mv=1, sv=1)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t   occ_p1;
    occ_t   occ_nxt;
    entry_t main_p1;
    entry_t skid_p1;
    entry_t in_entry;
    logic   in_xfer;
    logic   out_xfer;
    logic   load_main_in;
    logic   load_main_skid;
    logic   load_skid;

    // A write to register 0 is never useful, so the enable can be dropped at capture.
    function automatic logic gate_reg_write(input logic rw, input logic [RD_W-1:0] rd);
        if (ZERO_REG_NOWR != 0)
            return rw & (rd != '0);
        else
            return rw;
    endfunction

    always_comb begin
        in_entry            = '0;
        in_entry.mem_to_reg = in_mem_to_reg;
        in_entry.reg_write  = gate_reg_write(in_reg_write, in_rd);
        in_entry.alu_out    = in_alu_out;
        in_entry.mem_data   = in_mem_data;
        in_entry.rd         = in_rd;
        in_entry.opcode     = in_opcode;
    end

    assign in_ready  = (occ_p1 != FULL);
    assign out_valid = (occ_p1 != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Next-state and register-load selection
    always_comb begin
        occ_nxt        = occ_p1;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ_p1)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    occ_nxt      = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    occ_nxt   = FULL;
                end else if (out_xfer) begin
                    occ_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low in this state, so only a drain can happen
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    occ_nxt        = ONE;
                end
            end
            default: occ_nxt = EMPTY;
        endcase
    end

    // Stage boundary: occupancy, main and skid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_p1  <= EMPTY;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else if (flush) begin
            occ_p1  <= EMPTY;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            occ_p1 <= occ_nxt;
            if (load_main_in)
                main_p1 <= in_entry;
            else if (load_main_skid)
                main_p1 <= skid_p1;
            if (load_skid)
                skid_p1 <= in_entry;
        end
    end

    assign out_mem_to_reg = main_p1.mem_to_reg;
    assign out_reg_write  = main_p1.reg_write & out_valid;
    assign out_alu_out    = main_p1.alu_out;
    assign out_mem_data   = main_p1.mem_data;
    assign out_rd         = main_p1.rd;
    assign out_opcode     = main_p1.opcode;

`ifdef MEMWB_WBMUX_EN
    assign wb_data    = out_valid ? (main_p1.mem_to_reg ? main_p1.mem_data : main_p1.alu_out)
                                  : '0;
    assign wb_fwd_hit = out_valid & out_reg_write & (main_p1.rd == fwd_rs);
`endif

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_to_reg;
    logic              in_reg_write;
    logic [DATA_W-1:0] in_alu_out;
    logic [DATA_W-1:0] in_mem_data;
    logic [RD_W-1:0]   in_rd;
    logic [OP_W-1:0]   in_opcode;
    logic              out_valid;
    logic              out_ready;
    logic              out_mem_to_reg;
    logic              out_reg_write;
    logic [DATA_W-1:0] out_alu_out;
    logic [DATA_W-1:0] out_mem_data;
    logic [RD_W-1:0]   out_rd;
    logic [OP_W-1:0]   out_opcode;
`ifdef MEMWB_WBMUX_EN
    logic [RD_W-1:0]   fwd_rs;
    logic [DATA_W-1:0] wb_data;
    logic              wb_fwd_hit;
`endif

    int checks   = 0;
    int failures = 0;

    memwb_stage #(
        .DATA_W(DATA_W), .RD_W(RD_W), .OP_W(OP_W), .ZERO_REG_NOWR(1)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_out(in_alu_out), .in_mem_data(in_mem_data),
        .in_rd(in_rd), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_alu_out(out_alu_out), .out_mem_data(out_mem_data),
        .out_rd(out_rd), .out_opcode(out_opcode)
`ifdef MEMWB_WBMUX_EN
        , .fwd_rs(fwd_rs), .wb_data(wb_data), .wb_fwd_hit(wb_fwd_hit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic        m2r;
        logic        rw;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [3:0]  rd;
        logic [3:0]  op;
        logic        e_ir;
        logic        e_ov;
        logic        e_rw;
        logic        chk;   // compare the data fields too
        logic        e_m2r;
        logic [15:0] e_alu;
        logic [15:0] e_mem;
        logic [3:0]  e_rd;
        logic [3:0]  e_op;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Input vector; the expected head is given as separate fields.
    task automatic add(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic m2r, input logic rw, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [3:0] rd, input logic [3:0] op,
                       input logic e_ir, input logic e_ov, input logic e_rw, input logic chk,
                       input logic e_m2r, input logic [15:0] e_alu, input logic [15:0] e_mem,
                       input logic [3:0] e_rd, input logic [3:0] e_op);
        vec_t v;
        v = '{rst, fl, iv, ordy, m2r, rw, alu, mem, rd, op,
              e_ir, e_ov, e_rw, chk, e_m2r, e_alu, e_mem, e_rd, e_op};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic m2r, input logic rw, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [3:0] rd, input logic [3:0] op);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
        in_mem_to_reg = m2r; in_reg_write = rw; in_alu_out = alu;
        in_mem_data = mem; in_rd = rd; in_opcode = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
`ifdef MEMWB_WBMUX_EN
        fwd_rs = '0;
`endif
        step(); step();
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_reg_write", out_reg_write, 0);
        check("rst_alu", out_alu_out, 0);
        check("rst_mem", out_mem_data, 0);
        check("rst_rd", out_rd, 0);
        check("rst_op", out_opcode, 0);
        check("rst_m2r", out_mem_to_reg, 0);

        // rst fl iv or m2r rw alu mem rd op | ir ov rw chk m2r alu mem rd op
        // 0: first entry appears after one cycle
        add(0,0,1,1, 0,1,16'h1234,16'h0001,4'd3,4'h1, 1,1,1,1, 0,16'h1234,16'h0001,4'd3,4'h1);
        // 1-4: four back-to-back beats at full throughput
        add(0,0,1,1, 1,1,16'h0A01,16'h1A01,4'd1,4'h2, 1,1,1,1, 1,16'h0A01,16'h1A01,4'd1,4'h2);
        add(0,0,1,1, 0,1,16'h0A02,16'h1A02,4'd2,4'h3, 1,1,1,1, 0,16'h0A02,16'h1A02,4'd2,4'h3);
        add(0,0,1,1, 1,0,16'h0A03,16'h1A03,4'd3,4'h4, 1,1,0,1, 1,16'h0A03,16'h1A03,4'd3,4'h4);
        add(0,0,1,1, 0,1,16'h0A04,16'h1A04,4'd4,4'h5, 1,1,1,1, 0,16'h0A04,16'h1A04,4'd4,4'h5);
        // 5: drain to empty
        add(0,0,0,1, 0,0,16'h0000,16'h0000,4'd0,4'h0, 1,0,0,0, 0,16'h0,16'h0,4'd0,4'h0);
        // 6-7: A then B under stall -> full, A held
        add(0,0,1,0, 0,1,16'h00A0,16'h10A0,4'd6,4'h6, 1,1,1,1, 0,16'h00A0,16'h10A0,4'd6,4'h6);
        add(0,0,1,0, 1,1,16'h00B0,16'h10B0,4'd7,4'h7, 0,1,1,1, 0,16'h00A0,16'h10A0,4'd6,4'h6);
        // 8: C offered while full is refused
        add(0,0,1,0, 0,1,16'h00C0,16'h10C0,4'd8,4'h8, 0,1,1,1, 0,16'h00A0,16'h10A0,4'd6,4'h6);
        // 9: drain A, B moves to head; C still refused this edge
        add(0,0,1,1, 0,1,16'h00C0,16'h10C0,4'd8,4'h8, 1,1,1,1, 1,16'h00B0,16'h10B0,4'd7,4'h7);
        // 10: C accepted into skid while B stalls
        add(0,0,1,0, 0,1,16'h00C0,16'h10C0,4'd8,4'h8, 0,1,1,1, 1,16'h00B0,16'h10B0,4'd7,4'h7);
        // 11-12: drain B then C
        add(0,0,0,1, 0,0,16'h0000,16'h0000,4'd0,4'h0, 1,1,1,1, 0,16'h00C0,16'h10C0,4'd8,4'h8);
        add(0,0,0,1, 0,0,16'h0000,16'h0000,4'd0,4'h0, 1,0,0,0, 0,16'h0,16'h0,4'd0,4'h0);
        // 13-14: fill up
        add(0,0,1,0, 0,1,16'h00D1,16'h10D1,4'd9,4'h9, 1,1,1,1, 0,16'h00D1,16'h10D1,4'd9,4'h9);
        add(0,0,1,0, 0,1,16'h00D2,16'h10D2,4'd9,4'h9, 0,1,1,1, 0,16'h00D1,16'h10D1,4'd9,4'h9);
        // 15: flush while full with D offered -> empty, zeroed
        add(0,1,1,0, 0,1,16'h00DD,16'h10DD,4'd10,4'hA, 1,0,0,1, 0,16'h0,16'h0,4'd0,4'h0);
        // 16: D never appears
        add(0,0,0,1, 0,0,16'h0000,16'h0000,4'd0,4'h0, 1,0,0,1, 0,16'h0,16'h0,4'd0,4'h0);
        // 17: rd=0 suppresses reg_write
        add(0,0,1,1, 0,1,16'h0777,16'h1777,4'd0,4'hB, 1,1,0,1, 0,16'h0777,16'h1777,4'd0,4'hB);
        // 18: reg_write=0 passes through as 0
        add(0,0,1,1, 0,0,16'h0555,16'h1555,4'd5,4'hC, 1,1,0,1, 0,16'h0555,16'h1555,4'd5,4'hC);
        // 19: fields with in_valid=0 are ignored
        add(0,0,0,1, 1,1,16'hFFFF,16'hFFFF,4'd2,4'hF, 1,0,0,0, 0,16'h0,16'h0,4'd0,4'h0);
        // 20-22: reset in the middle of a stall loses both entries
        add(0,0,1,0, 1,1,16'h00E1,16'h10E1,4'd11,4'hD, 1,1,1,1, 1,16'h00E1,16'h10E1,4'd11,4'hD);
        add(0,0,1,0, 0,1,16'h00E2,16'h10E2,4'd12,4'hE, 0,1,1,1, 1,16'h00E1,16'h10E1,4'd11,4'hD);
        add(1,0,1,1, 0,1,16'h00E3,16'h10E3,4'd13,4'hE, 1,0,0,1, 0,16'h0,16'h0,4'd0,4'h0);
        add(0,0,0,1, 0,0,16'h0000,16'h0000,4'd0,4'h0, 1,0,0,1, 0,16'h0,16'h0,4'd0,4'h0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.fl, v.iv, v.ordy, v.m2r, v.rw, v.alu, v.mem, v.rd, v.op);
            step();
            check($sformatf("v%0d_in_ready", i), in_ready, v.e_ir);
            check($sformatf("v%0d_out_valid", i), out_valid, v.e_ov);
            check($sformatf("v%0d_reg_write", i), out_reg_write, v.e_rw);
            if (v.chk) begin
                check($sformatf("v%0d_alu", i), out_alu_out, v.e_alu);
                check($sformatf("v%0d_mem", i), out_mem_data, v.e_mem);
                check($sformatf("v%0d_rd", i), out_rd, v.e_rd);
                check($sformatf("v%0d_op", i), out_opcode, v.e_op);
                check($sformatf("v%0d_m2r", i), out_mem_to_reg, v.e_m2r);
            end
        end

        // Long stall: head stays constant over several cycles while full
        drive(0, 0, 1, 0, 0, 1, 16'h0F01, 16'h1F01, 4'd1, 4'h1);
        step();
        drive(0, 0, 1, 0, 1, 1, 16'h0F02, 16'h1F02, 4'd2, 4'h2);
        step();
        drive(0, 0, 1, 0, 1, 0, 16'h0F03, 16'h1F03, 4'd3, 4'h3);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_alu", k), out_alu_out, 16'h0F01);
            check($sformatf("stall%0d_rd", k), out_rd, 4'd1);
            check($sformatf("stall%0d_in_ready", k), in_ready, 0);
            check($sformatf("stall%0d_out_valid", k), out_valid, 1);
        end
        drive(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 4'd0, 4'h0);
        step();
        check("drain_f2_alu", out_alu_out, 16'h0F02);
        check("drain_f2_m2r", out_mem_to_reg, 1);
        step();
        check("drain_empty", out_valid, 0);

`ifdef MEMWB_WBMUX_EN
        check("wb_data_idle", wb_data, 0);
        fwd_rs = 4'd5;
        drive(0, 0, 1, 0, 1, 1, 16'h0010, 16'hBEEF, 4'd5, 4'h1);
        step();
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 4'd0, 4'h0);
        #1;
        check("wb_data_mem", wb_data, 16'hBEEF);
        check("wb_fwd_hit_5", wb_fwd_hit, 1);
        fwd_rs = 4'd6;
        #1;
        check("wb_fwd_hit_6", wb_fwd_hit, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_mem_to_reg = 1'b0; in_reg_write = 1'b1;
        in_alu_out = 16'h0010; in_mem_data = 16'hBEEF; in_rd = 4'd6;
        step();
        check("wb_data_alu", wb_data, 16'h0010);
        check("wb_fwd_hit_alu", wb_fwd_hit, 1);
        in_valid = 1'b0;
        step();
        check("wb_data_empty", wb_data, 0);
        check("wb_fwd_hit_empty", wb_fwd_hit, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- Parametrised MEM/WB pipeline stage sitting between the data-memory stage and register-file writeback.
- Replaces the fixed 16-bit single-register MEM/WB latch with a 2-entry elastic stage: a main register plus a skid register.
- Uses a valid/ready handshake, so writeback backpressure never drops an instruction.
- Provides synchronous flush (bubble insertion) and optional suppression of writes to register 0.

Parameters:
- DATA_W, 16, width of ALU result and memory read data.
- RD_W, 4, destination register index width.
- OP_W, 4, opcode width.
- ZERO_REG_NOWR, 1, when 1 a transfer with rd==0 is stored with reg_write forced to 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_mem_to_reg  in  1  select memory data for writeback.
- in_reg_write  in  1  register write enable.
- in_alu_out  in  DATA_W  ALU result / address.
- in_mem_data  in  DATA_W  data-memory read data.
- in_rd  in  RD_W  destination register.
- in_opcode  in  OP_W  opcode.
- out_valid  out  1  head entry present.
- out_ready  in  1  writeback consumes head.
- out_mem_to_reg  out  1  head field.
- out_reg_write  out  1  head field, gated by out_valid.
- out_alu_out  out  DATA_W  head field.
- out_mem_data  out  DATA_W  head field.
- out_rd  out  RD_W  head field.
- out_opcode  out  OP_W  head field.

Behaviour:
- Transfers:
  - Input transfer is in_valid & in_ready.
  - Output transfer is out_valid & out_ready.
- Storage:
  - Main register M (valid bit mv) drives all out_* ports.
  - Skid register S (valid bit sv).
- Ready:
  - in_ready = ~sv, registered; not combinationally dependent on out_ready.
- Priority per edge: reset > flush > normal.
- Reset:
  - mv=0, sv=0, all stored fields 0.
  - After reset: out_valid=0, in_ready=1, out_reg_write=0, all data outputs 0.
- Flush:
  - mv=0 and sv=0 next cycle; stored fields zeroed.
  - An input presented in the same cycle is dropped.
  - in_ready=1 the following cycle.
- Normal operation, with occupancy states EMPTY (mv=0), ONE (mv=1, sv=0), FULL (mv=1, sv=1):
  - EMPTY + input -> M loads, ONE.
  - ONE + input + output -> M reloads, ONE (full throughput, 1 entry/cycle).
  - ONE + input, no output -> S loads, FULL, in_ready drops next cycle.
  - ONE + output only -> EMPTY.
  - FULL + output -> M takes S, sv=0, ONE; no input accepted since in_ready=0.
  - FULL, no output -> hold.
- Latency: 1 cycle from input transfer to out_valid when empty.
- Ordering: strict FIFO order, no duplication, no loss except on flush/reset.
- Out-of-handshake inputs: in_* ignored when in_valid=0.
- out_reg_write:
  - Equals M.reg_write & mv; never asserts while out_valid=0.
  - With ZERO_REG_NOWR=1, reg_write is captured as in_reg_write & (in_rd != 0).
- Stall stability: all out_* fields hold constant while out_valid=1 and out_ready=0.
- Reset mid-stall: both entries are lost; no partial state survives.

Optional Feature:
- Macro MEMWB_WBMUX_EN.
- When defined, adds two outputs:
  - wb_data (DATA_W) = out_mem_to_reg ? out_mem_data : out_alu_out, combinational from M; 0 when out_valid=0.
  - wb_fwd_hit (1) = out_valid & out_reg_write & (out_rd == fwd_rs).
- Also adds the input fwd_rs (RD_W), the consumer source register for the hazard unit.
- When not defined, these ports are absent and there is no other change.

Test Plan:
- Reset, then in_valid=1 with alu=0x1234, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_out=0x1234, out_rd=3, out_reg_write=1.
- Stream 4 entries back-to-back with out_ready=1 -> 4 consecutive output beats, in order, in_ready constantly 1.
- Push A, B with out_ready=0 -> in_ready=0 after B; out holds A. Raise out_ready -> A then B delivered. C offered while full is not accepted until in_ready=1.
- FULL state, assert flush with in_valid=1 (entry D) -> next cycle out_valid=0, in_ready=1; D never appears.
- ZERO_REG_NOWR=1, input rd=0, reg_write=1 -> out_valid=1, out_reg_write=0.
- MEMWB_WBMUX_EN, mem_to_reg=1, mem_data=0xBEEF, alu=0x0010, rd=5, fwd_rs=5 -> wb_data=0xBEEF, wb_fwd_hit=1; with fwd_rs=6 -> wb_fwd_hit=0.
